led_show_sequencer: RTL and testbench
=====================================

Name: led_show_sequencer

Overview:
- Controller for the 16-LED shift datapath.
- Steps the shifter through a fixed show: blink, shift right, shift left, centre-out, outside-in. Each phase runs for a programmable number of steps.
- Replaces the free-running divided clock with a single-clock design: a one-cycle step enable plus a load strobe. The shifter's mode/manual inputs come from this block.
- Sits between board switches/buttons and the shifter. Whole design stays on the 100 MHz clk.

Parameters:
- DIV0, 100_000_000, step period in clk cycles for sel_freq=0 (1 Hz)
- DIV1, 50_000_000, step period for sel_freq=1 (2 Hz)
- DIV2, 20_000_000, step period for sel_freq=2 (5 Hz)
- DIV3, 10_000_000, step period for sel_freq=3 (10 Hz)
- CNT_W, 27, prescaler width; must hold max(DIVn)-1

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-low (rst=0 at a clk rising edge resets the block)
- start  in  1  level; begins a show when FSM is in IDLE or DONE
- stop  in  1  level; abort to IDLE, highest priority after rst
- pause  in  1  level; freezes prescaler and step counter in RUN
- loop_en  in  1  1 = after last phase restart at phase 0; 0 = stop in DONE
- sel_freq  in  2  step-rate select, latched on every LOAD
- steps  in  8  steps per phase, latched on start; 0 is treated as 1
- shf_load  out  1  one-cycle strobe; shifter loads its initial pattern for shf_mode/shf_manual
- shf_step  out  1  one-cycle step enable to shifter
- shf_mode  out  2  shifter mode: 0 right, 1 left, 2 centre-out, 3 outside-in
- shf_manual  out  1  0 = blink (invert all), 1 = shift per shf_mode
- phase  out  3  current phase 0..4
- busy  out  1  high in LOAD and RUN
- done  out  1  high in DONE

Behaviour:
- Reset values: all registered.
  - state=IDLE, phase=0, shf_load=0, shf_step=0, shf_mode=0, shf_manual=1, busy=0, done=0.
  - Prescaler=0, step_cnt=0, latched steps=1, latched sel=0.
- Phase table (drives shf_manual/shf_mode):
  - phase 0: manual=0, mode=0
  - phase 1: manual=1, mode=0
  - phase 2: manual=1, mode=1
  - phase 3: manual=1, mode=2
  - phase 4: manual=1, mode=3
- States: IDLE, LOAD, RUN, DONE.
- IDLE / DONE:
  - start=1 at edge t → latch steps (0→1), phase=0, LOAD at t+1.
  - DONE holds done=1 until start or stop.
- LOAD (exactly one cycle):
  - shf_load=1; shf_manual/shf_mode already valid for the new phase.
  - Prescaler cleared, step_cnt cleared, sel_freq latched.
  - Next state RUN.
- RUN, prescaler:
  - When pause=0, the prescaler counts 0..DIVsel-1 and wraps.
  - At terminal count, shf_step=1 on the next cycle, and step_cnt increments.
  - The first shf_step occurs DIVsel cycles after the LOAD cycle.
- RUN, end of phase:
  - The cycle with shf_step=1 and step_cnt==steps-1 is the last step of the phase.
  - Next state LOAD with phase+1. After phase 4: phase 0 if loop_en=1, else DONE (phase stays 4).
- Pause:
  - Freezes prescaler and step_cnt; no shf_step while pause=1.
  - Resumes without loss or repeat.
- Stop:
  - In any state, stop=1 → IDLE next cycle.
  - Outputs return to reset values; a pending shf_step is suppressed.
- Precedence: rst > stop > start.
  - start is ignored in LOAD/RUN.
  - sel_freq changes mid-phase take effect at the next LOAD.
- Exclusivity: shf_load and shf_step are never high in the same cycle.
- rst low mid-show: full reset on that edge, identical to power-up.

Test Plan:
- DIV0=4, steps=3, sel=0, loop_en=0, pulse start:
  - shf_load at t+1; shf_step at t+5, t+9, t+13.
  - shf_load for phase 1 at t+14.
  - Phases 0..4 complete; done=1, busy=0; exactly 15 shf_step pulses total.
- Phase outputs:
  - Check (manual, mode) at each shf_load: (0,0), (1,0), (1,1), (1,2), (1,3).
  - Bench instantiates the shifter (load on shf_load, update on shf_step); LED after 3 steps in phase 1 is 16'h1000.
- Pause:
  - Assert pause 2 cycles before the second shf_step, hold 10 cycles.
  - Second step is delayed by exactly 10 cycles; step count is unchanged.
- Stop and restart:
  - stop mid-phase 2 → IDLE next cycle, shf_mode=0, shf_manual=1, no further pulses.
  - start again → restarts at phase 0.
- loop_en=1, steps=0 (treated as 1):
  - After phase 4 the next LOAD is phase 0; done never asserts; 5 pulses per loop.
- rst=0 held 1 cycle mid-RUN:
  - All outputs at reset values on the next cycle.
  - start ignored while rst=0.

Source files
------------

// File: rtl/led_show_sequencer.sv
// Show controller for the 16-LED shifter: walks blink, right, left, centre-out
// and outside-in phases, emitting single-cycle load/step strobes on one clock.
module led_show_sequencer #(
  parameter int unsigned DIV0  = 100_000_000,
  parameter int unsigned DIV1  = 50_000_000,
  parameter int unsigned DIV2  = 20_000_000,
  parameter int unsigned DIV3  = 10_000_000,
  parameter int unsigned CNT_W = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  input  logic [1:0] sel_freq,
  input  logic [7:0] steps,
  output logic       shf_load,
  output logic       shf_step,
  output logic [1:0] shf_mode,
  output logic       shf_manual,
  output logic [2:0] phase,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] DIV0_M1 = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] DIV1_M1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] DIV2_M1 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] DIV3_M1 = CNT_W'(DIV3 - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] div_m1;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic [7:0]       steps_q, steps_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       phase_q, phase_d;
  logic             load_q, load_d;
  logic             step_q, step_d;
  logic             manual_q, manual_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tc;
  logic             last_step;
  logic             counting;

  always_comb begin
    unique case (sel_q)
      2'd0:    div_m1 = DIV0_M1;
      2'd1:    div_m1 = DIV1_M1;
      2'd2:    div_m1 = DIV2_M1;
      default: div_m1 = DIV3_M1;
    endcase
  end

  assign tc        = (presc_q == div_m1);
  assign last_step = step_q && (step_cnt_q == (steps_q - 8'd1));
  // The LOAD cycle itself is prescaler count 0, so the first step lands DIVsel cycles after it.
  assign counting  = (state_q == S_LOAD) || ((state_q == S_RUN) && !pause);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    steps_d = steps_q;
    sel_d   = sel_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          phase_d = '0;
          steps_d = (steps == '0) ? 8'd1 : steps;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (last_step) begin
          if (phase_q == 3'd4) begin
            if (loop_en) begin
              state_d = S_LOAD;
              phase_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            state_d = S_LOAD;
            phase_d = phase_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d = S_IDLE;
      phase_d = '0;
    end

    if (state_d == S_LOAD) begin
      sel_d = sel_freq;
    end
  end

  always_comb begin
    presc_d    = presc_q;
    step_cnt_d = step_cnt_q;
    step_d     = 1'b0;

    if (state_d != S_RUN) begin
      presc_d    = '0;
      step_cnt_d = '0;
    end else begin
      if (counting) begin
        presc_d = tc ? '0 : presc_q + CNT_W'(1);
        step_d  = tc;
      end
      if (step_q) begin
        step_cnt_d = step_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    load_d   = (state_d == S_LOAD);
    busy_d   = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    manual_d = manual_q;
    mode_d   = mode_q;

    if (state_d == S_IDLE) begin
      manual_d = 1'b1;
      mode_d   = 2'd0;
    end else if (state_d == S_LOAD) begin
      unique case (phase_d)
        3'd0: begin manual_d = 1'b0; mode_d = 2'd0; end
        3'd1: begin manual_d = 1'b1; mode_d = 2'd0; end
        3'd2: begin manual_d = 1'b1; mode_d = 2'd1; end
        3'd3: begin manual_d = 1'b1; mode_d = 2'd2; end
        default: begin manual_d = 1'b1; mode_d = 2'd3; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      step_cnt_q <= '0;
      steps_q    <= 8'd1;
      sel_q      <= '0;
      phase_q    <= '0;
      load_q     <= 1'b0;
      step_q     <= 1'b0;
      manual_q   <= 1'b1;
      mode_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      step_cnt_q <= step_cnt_d;
      steps_q    <= steps_d;
      sel_q      <= sel_d;
      phase_q    <= phase_d;
      load_q     <= load_d;
      step_q     <= step_d;
      manual_q   <= manual_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign shf_load   = load_q;
  assign shf_step   = step_q;
  assign shf_mode   = mode_q;
  assign shf_manual = manual_q;
  assign phase      = phase_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_led_show_sequencer.sv
// Bench for led_show_sequencer: per-cycle compare against a countdown-based
// show model, plus literal timing/phase expectations and a shifter for LEDs.
module tb_led_show_sequencer;

  localparam int unsigned D0 = 4;
  localparam int unsigned D1 = 6;
  localparam int unsigned D2 = 3;
  localparam int unsigned D3 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop_en = 1'b0;
  logic [1:0] sel_freq = 2'd0;
  logic [7:0] steps = 8'd0;
  logic       shf_load, shf_step, shf_manual, busy, done;
  logic [1:0] shf_mode;
  logic [2:0] phase;

  led_show_sequencer #(
    .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .sel_freq(sel_freq), .steps(steps),
    .shf_load(shf_load), .shf_step(shf_step), .shf_mode(shf_mode),
    .shf_manual(shf_manual), .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  // ---------------- show model ----------------
  int unsigned divs[4] = '{D0, D1, D2, D3};
  logic       e_load = 1'b0, e_step = 1'b0, e_manual = 1'b1, e_busy = 1'b0, e_done = 1'b0;
  logic [1:0] e_mode = 2'd0;
  logic [2:0] e_phase = 3'd0;
  bit         m_active = 1'b0;
  int         m_steps = 1, m_left = 0, m_wait = 0, m_div = 1;

  task automatic m_reset();
    e_load = 1'b0; e_step = 1'b0; e_manual = 1'b1; e_mode = 2'd0;
    e_phase = 3'd0; e_busy = 1'b0; e_done = 1'b0; m_active = 1'b0;
  endtask

  task automatic m_begin(input int p);
    e_phase  = 3'(p);
    e_load   = 1'b1;
    e_step   = 1'b0;
    e_busy   = 1'b1;
    e_done   = 1'b0;
    e_manual = (p != 0);
    e_mode   = (p == 0) ? 2'd0 : 2'(p - 1);
    m_div    = int'(divs[sel_freq]);
    m_wait   = m_div;
    m_left   = m_steps;
    m_active = 1'b1;
  endtask

  // One counted cycle elapses; a step follows once DIV of them have passed.
  task automatic m_tick();
    m_wait--;
    if (m_wait == 0) begin
      e_step = 1'b1;
      m_wait = m_div;
    end else begin
      e_step = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_reset();
      m_steps = 1;
    end else if (stop) begin
      m_reset();
    end else if (!m_active) begin
      if (start) begin
        m_steps = (steps == 8'd0) ? 1 : int'(steps);
        m_begin(0);
      end
    end else if (e_load) begin
      e_load = 1'b0;
      m_tick();
    end else begin
      if (e_step) m_left--;
      if (e_step && m_left == 0) begin
        if (e_phase == 3'd4) begin
          if (loop_en) m_begin(0);
          else begin
            m_active = 1'b0;
            e_step = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b1;
          end
        end else begin
          m_begin(int'(e_phase) + 1);
        end
      end else begin
        e_step = 1'b0;
        if (!pause) m_tick();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs", 32'({shf_load, shf_step, shf_manual, shf_mode, phase, busy, done}),
          32'({e_load, e_step, e_manual, e_mode, e_phase, e_busy, e_done}));
      chk("load_step_exclusive", 32'(shf_load & shf_step), 32'd0);
    end
  end

  // ---------------- shifter and monitors ----------------
  logic [15:0] led = 16'h0000;
  logic [15:0] led_snap = 16'h0000;
  int   load_cyc[$];
  logic [5:0] load_tag[$];
  int   step_cyc[$];
  int   done_seen = 0;

  always @(posedge clk) begin
    if (shf_load) begin
      if (!shf_manual) led <= 16'h0000;
      else case (shf_mode)
        2'd0: led <= 16'h8000;
        2'd1: led <= 16'h0001;
        2'd2: led <= 16'h0180;
        default: led <= 16'h8001;
      endcase
    end else if (shf_step) begin
      if (!shf_manual) led <= ~led;
      else case (shf_mode)
        2'd0: led <= {led[0], led[15:1]};
        2'd1: led <= {led[14:0], led[15]};
        2'd2: led <= {led[14:8], 1'b0, 1'b0, led[7:1]};
        default: led <= {1'b0, led[15:9], led[6:0], 1'b0};
      endcase
    end
  end

  always @(negedge clk) begin
    if (shf_load) begin
      load_cyc.push_back(cyc);
      load_tag.push_back({shf_manual, shf_mode, phase});
      if (phase == 3'd2) led_snap = led;
    end
    if (shf_step) step_cyc.push_back(cyc);
    if (done) done_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic clear_log();
    load_cyc.delete();
    load_tag.delete();
    step_cyc.delete();
    done_seen = 0;
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1;
    t = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int t;
  logic [5:0] exp_tag[5] = '{6'b000000, 6'b100001, 6'b101010, 6'b110011, 6'b111100};

  initial begin
    tick(1);
    chk_en = 1'b1;
    tick(1);
    chk("reset_outputs", 32'({shf_load, shf_step, shf_manual, shf_mode, phase, busy, done}),
        32'b0010000000);

    // Basic show: steps=3, 1x rate, no loop
    rst = 1'b1; steps = 8'd3; sel_freq = 2'd0; loop_en = 1'b0;
    tick(2);
    clear_log();
    pulse_start(t);
    wait_done(200);
    chk("done_reached", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("first_load", 32'(load_cyc[0]), 32'(t + 1));
    chk("step1", 32'(step_cyc[0]), 32'(t + 5));
    chk("step2", 32'(step_cyc[1]), 32'(t + 9));
    chk("step3", 32'(step_cyc[2]), 32'(t + 13));
    chk("phase1_load", 32'(load_cyc[1]), 32'(t + 14));
    chk("step_total", 32'(step_cyc.size()), 32'd15);
    chk("load_total", 32'(load_cyc.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("phase_tag", 32'(load_tag[i]), 32'(exp_tag[i]));
    chk("led_phase1", 32'(led_snap), 32'h1000);
    chk("done_phase", 32'({shf_manual, shf_mode, phase}), 32'b111100);

    // Pause before second step, then stop mid phase 2 (start from DONE)
    tick(3);
    clear_log();
    pulse_start(t);
    tick_to(t + 7);
    pause = 1'b1;
    tick(10);
    pause = 1'b0;
    tick_to(t + 44);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_idle", 32'({shf_step, shf_manual, shf_mode, phase, busy, done}), 32'b010000000);
    tick(20);
    chk("pause_step1", 32'(step_cyc[0]), 32'(t + 5));
    chk("pause_step2", 32'(step_cyc[1]), 32'(t + 19));
    chk("pause_step3", 32'(step_cyc[2]), 32'(t + 23));
    chk("pause_phase1_load", 32'(load_cyc[1]), 32'(t + 24));
    chk("stop_step_total", 32'(step_cyc.size()), 32'd7);
    chk("stop_load_total", 32'(load_cyc.size()), 32'd3);

    // Restart with loop, steps=0 treated as 1, rate change mid-phase
    clear_log();
    steps = 8'd0; loop_en = 1'b1; sel_freq = 2'd2;
    pulse_start(t);
    tick_to(t + 23);
    sel_freq = 2'd1;
    tick_to(t + 60);
    for (int i = 0; i < 6; i++) chk("loop_tag", 32'(load_tag[i][2:0]), 32'(i % 5));
    chk("loop_step1", 32'(step_cyc[0]), 32'(t + 4));
    chk("loop_wrap_load", 32'(load_cyc[5]), 32'(t + 21));
    chk("sel_change_load", 32'(load_cyc[6]), 32'(t + 25));
    chk("sel_change_next", 32'(load_cyc[7]), 32'(t + 32));
    chk("loop_no_done", 32'(done_seen), 32'd0);

    // Reset mid-run with start held: full reset, start ignored
    rst = 1'b0; start = 1'b1;
    tick(1);
    chk("rst_outputs", 32'({shf_load, shf_step, shf_manual, shf_mode, phase, busy, done}),
        32'b0010000000);
    rst = 1'b1; start = 1'b0;
    tick(5);
    chk("rst_stays_idle", 32'(busy), 32'd0);

    // Fast rate, two steps per phase, to DONE
    clear_log();
    steps = 8'd2; loop_en = 1'b0; sel_freq = 2'd3;
    pulse_start(t);
    wait_done(200);
    chk("fast_done", 32'(done), 32'd1);
    chk("fast_step_total", 32'(step_cyc.size()), 32'd10);
    chk("fast_step1", 32'(step_cyc[0]), 32'(t + 3));
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
